// File: rtl/seg7_scan4.sv
// rtl/seg7_scan4.sv - 4-digit multiplexed 7-segment scan controller
// New values commit only at frame boundaries so a frame never mixes old and new digits.
module seg7_scan4 #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] din,
  input  logic        lzb,
  output logic        ack,
  output logic [3:0]  z,
  output logic [3:0]  an,
  output logic        blank
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] presc;
  logic [1:0]   idx;
  logic [15:0]  disp;
  logic [15:0]  pend;
  logic         pv;
  logic         tick;
  logic         boundary;

  assign tick     = (presc == LAST);
  assign boundary = tick && (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= 2'd0;
      disp  <= 16'h0000;
      pend  <= 16'h0000;
      pv    <= 1'b0;
      ack   <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (tick) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + W'(1);
      end
      if (boundary && pv) begin
        disp <= pend;
        pv   <= 1'b0;
        ack  <= 1'b1;
      end
      // A load in the commit cycle wins over the pv clear: the new value waits a frame.
      if (load) begin
        pend <= din;
        pv   <= 1'b1;
      end
    end
  end

  logic       lead_zero;
  logic [3:0] nib;

  always_comb begin
    lead_zero = 1'b0;
    nib       = disp[3:0];
    case (idx)
      2'd0: begin nib = disp[3:0];   lead_zero = 1'b0;                   end
      2'd1: begin nib = disp[7:4];   lead_zero = (disp[15:4]  == 12'h0); end
      2'd2: begin nib = disp[11:8];  lead_zero = (disp[15:8]  == 8'h0);  end
      2'd3: begin nib = disp[15:12]; lead_zero = (disp[15:12] == 4'h0);  end
      default: begin nib = 4'h0; lead_zero = 1'b0; end
    endcase
  end

  always_comb begin
    blank = lzb && lead_zero;
    if (blank) begin
      z  = 4'h0;
      an = 4'b1111;
    end else begin
      z  = nib;
      an = ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_seg7_scan4.sv
// tb/tb_seg7_scan4.sv - directed bench for seg7_scan4 with a cycle-count reference model
module tb_seg7_scan4;

  localparam int DIV = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        lzb = 1'b0;
  logic        ack;
  logic [3:0]  z;
  logic [3:0]  an;
  logic        blank;

  seg7_scan4 #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .din(din), .lzb(lzb),
    .ack(ack), .z(z), .an(an), .blank(blank)
  );

  always #5 clk = ~clk;

  // Reference: position in the frame follows from the edge count since reset.
  int          t;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic        m_pv;
  logic        m_ack;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t      <= 0;
      m_disp <= 16'h0000;
      m_pend <= 16'h0000;
      m_pv   <= 1'b0;
      m_ack  <= 1'b0;
    end else begin
      t <= t + 1;
      if ((t % FRAME) == FRAME - 1 && m_pv) begin
        m_disp <= m_pend;
        m_ack  <= 1'b1;
      end else begin
        m_ack <= 1'b0;
      end
      if (load) begin
        m_pend <= din;
        m_pv   <= 1'b1;
      end else if ((t % FRAME) == FRAME - 1) begin
        m_pv <= 1'b0;
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int n = 0;
  int acks = 0;
  bit en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: actual=%h required=%h", name, n, act, exp);
    end
  endtask

  task automatic cmp_model();
    int          e_idx;
    logic [15:0] rest;
    logic        e_blank;
    logic [3:0]  e_z;
    logic [3:0]  e_an;
    e_idx   = (t / DIV) % 4;
    rest    = m_disp >> (4 * e_idx);
    e_blank = lzb && (e_idx != 0) && (rest == 16'h0);
    e_z     = e_blank ? 4'h0 : rest[3:0];
    e_an    = e_blank ? 4'b1111 : ~(4'b0001 << e_idx);
    chk("model_z", {12'h0, z}, {12'h0, e_z});
    chk("model_an", {12'h0, an}, {12'h0, e_an});
    chk("model_blank", {15'h0, blank}, {15'h0, e_blank});
    chk("model_ack", {15'h0, ack}, {15'h0, m_ack});
  endtask

  task automatic cyc();
    @(negedge clk);
    n++;
    if (ack === 1'b1) acks++;
    if (en) cmp_model();
  endtask

  task automatic run_to(input int k);
    while (n < k) cyc();
  endtask

  task automatic lit(input string name, input logic [3:0] ez, input logic [3:0] ean,
                     input logic eb);
    chk({name, "_z"}, {12'h0, z}, {12'h0, ez});
    chk({name, "_an"}, {12'h0, an}, {12'h0, ean});
    chk({name, "_blank"}, {15'h0, blank}, {15'h0, eb});
  endtask

  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    n = 0;
    en = 1'b1;
    lit("reset", 4'h0, 4'b1110, 1'b0);
    chk("reset_ack", {15'h0, ack}, 16'h0);

    // Basic load on the 2nd cycle; idx stepping checked along the way
    run_to(1);
    load = 1'b1; din = 16'h1234;
    cyc();
    load = 1'b0;
    run_to(3);  chk("idx0_an", {12'h0, an}, 16'h000e);
    run_to(4);  chk("idx1_an", {12'h0, an}, 16'h000d);
    run_to(8);  chk("idx2_an", {12'h0, an}, 16'h000b);
    run_to(12); chk("idx3_an", {12'h0, an}, 16'h0007);
    run_to(15); chk("ack_before", {15'h0, ack}, 16'h0);
    run_to(16); chk("ack_commit", {15'h0, ack}, 16'h1);
    lit("d0_1234", 4'h4, 4'b1110, 1'b0);
    run_to(17); chk("ack_single", {15'h0, ack}, 16'h0);
    run_to(20); lit("d1_1234", 4'h3, 4'b1101, 1'b0);
    run_to(24); lit("d2_1234", 4'h2, 4'b1011, 1'b0);
    run_to(28); lit("d3_1234", 4'h1, 4'b0111, 1'b0);

    // Leading-zero blanking
    run_to(29);
    load = 1'b1; din = 16'h0050; lzb = 1'b1;
    cyc();
    load = 1'b0;
    run_to(32); lit("lzb_d0", 4'h0, 4'b1110, 1'b0);
    run_to(36); lit("lzb_d1", 4'h5, 4'b1101, 1'b0);
    run_to(40); lit("lzb_d2", 4'h0, 4'b1111, 1'b1);
    run_to(44); lit("lzb_d3", 4'h0, 4'b1111, 1'b1);
    run_to(45);
    load = 1'b1; din = 16'h0000;
    cyc();
    load = 1'b0;
    run_to(48); lit("zero_d0", 4'h0, 4'b1110, 1'b0);
    run_to(52); lit("zero_d1", 4'h0, 4'b1111, 1'b1);
    run_to(55);
    lzb = 1'b0;
    cyc();
    lit("relit_d2", 4'h0, 4'b1011, 1'b0);

    // Overwrite within a frame
    run_to(64);
    acks = 0;
    run_to(65);
    load = 1'b1; din = 16'hAAAA;
    cyc();
    load = 1'b0;
    run_to(69);
    load = 1'b1; din = 16'hBBBB;
    cyc();
    load = 1'b0;
    run_to(80); lit("ovw_d0", 4'hB, 4'b1110, 1'b0);
    run_to(92); lit("ovw_d3", 4'hB, 4'b0111, 1'b0);
    run_to(95); chk("ovw_ack_count", acks[15:0], 16'd1);

    // Load coincident with commit
    run_to(97);
    load = 1'b1; din = 16'h1111;
    cyc();
    load = 1'b0;
    run_to(111);
    load = 1'b1; din = 16'h2222;
    cyc();
    load = 1'b0;
    chk("coin_ack1", {15'h0, ack}, 16'h1);
    chk("coin_z1", {12'h0, z}, 16'h1);
    run_to(113); chk("coin_ack_gap", {15'h0, ack}, 16'h0);
    run_to(127); chk("coin_ack_pre2", {15'h0, ack}, 16'h0);
    run_to(128);
    chk("coin_ack2", {15'h0, ack}, 16'h1);
    chk("coin_z2", {12'h0, z}, 16'h2);

    // Asynchronous reset mid-slot of digit 2 with a value pending
    run_to(133);
    load = 1'b1; din = 16'h3333;
    cyc();
    load = 1'b0;
    run_to(137);
    lit("pre_rst", 4'h2, 4'b1011, 1'b0);
    #1 rst = 1'b1;
    #1;
    lit("async_rst", 4'h0, 4'b1110, 1'b0);
    chk("async_rst_ack", {15'h0, ack}, 16'h0);
    cyc();
    cyc();
    rst = 1'b0;
    n = 0;
    acks = 0;
    run_to(16); lit("post_rst_d0", 4'h0, 4'b1110, 1'b0);
    run_to(40); chk("post_rst_acks", acks[15:0], 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
